csh_pgrf_seq: RTL
=================

// Module: csh_pgrf_seq
// PURPOSE
//  Page-refill sequencer in the MBox cache-control (CSH) section. Sits directly upstream of the
//  PAG page-table board: on a PT miss it fetches the page-map word, writes it into the PT/PT-dir,
//  then retries the lookup. It produces the refill-cycle, T12, PT-dir-write, refill-error and
//  page-fail-hold strobes, plus the 5-bit PF-hold code.
// PARAMETERS
//  TMO_CYC    64  memory data-valid timeout, in clocks (2..255)
//  MAX_RETRY  2   refill attempts allowed before a miss is declared a refill error (1..7)
// PORTS
//  clk                      in   1  MBox clock
//  crobar_l                 in   1  async active-low reset
//  ebox_cyc_a_h             in   1  EBox paged reference in progress (qualifies PAG results)
//  pag_page_refill_l        in   1  PAG: PT miss, refill needed (low-true)
//  pag_page_fail_l          in   1  PAG: access violation (low-true)
//  pag_page_ok_l            in   1  PAG: translation good (low-true)
//  mem_rd_req_h             out  1  request a page-map word read
//  mem_rd_ack_h             in   1  memory accepted the request
//  mem_data_vld_h           in   1  map word returned this cycle
//  mem_par_err_h            in   1  parity error on the returned word (same cycle as data valid)
//  pf_ack_h                 in   1  EBox has read the PF word; release the hold
//  pgrf_cyc_a_h             out  1  refill cycle active (REQ..CHK)
//  page_refill_t12_l        out  1  one-clock strobe: retry the PT lookup
//  mbox_pt_dir_wr_l         out  1  one-clock PT and PT-dir write strobe
//  page_refill_error_h      out  1  refill error flag
//  page_refill_error_l      out  1  complement of page_refill_error_h
//  page_fail_hold_l         out  1  hold the page-fail word for the EBox
//  pf_hold_code_h           out  5  page-fail code, registered at entry to FAIL
// BEHAVIOUR
//  Reset values: state IDLE; all _l outputs 1; all _h outputs 0 except page_refill_error_l=1;
//   pf_hold_code_h=0; retry and timeout counters 0. Assertion of crobar_l at any time, including
//   mid-refill, returns to IDLE immediately and drops mem_rd_req_h. No pending request is remembered.
//  All outputs are registered. Every PAG input is sampled only when ebox_cyc_a_h=1.
//  Priority among PAG inputs: fail > refill > ok.
//  IDLE: fail -> FAIL, code 5'o01. Refill -> REQ with retry=1. Ok or nothing -> stay in IDLE.
//  REQ: mem_rd_req_h=1 and held until the clock in which mem_rd_ack_h=1; then WAIT with tmo=0.
//   If ack and data valid arrive together, the data is taken and the state advances to WR.
//  WAIT: tmo increments each clock. Data valid with no parity error -> WR.
//   Data valid with parity error -> FAIL, code 5'o02, page_refill_error_h=1.
//   tmo==TMO_CYC-1 with no data -> FAIL, code 5'o03, error flag set.
//   If data valid and timeout coincide, the data wins.
//  WR: mbox_pt_dir_wr_l=0 for exactly 1 clock; next state is T12.
//  T12: page_refill_t12_l=0 for exactly 1 clock; next state is CHK.
//  CHK: waits for a PAG result. Ok -> IDLE (retry cleared). Fail -> FAIL, code 5'o04.
//   Refill with retry<MAX_RETRY -> retry+1 and back to REQ.
//   Refill with retry==MAX_RETRY -> FAIL, code 5'o05, error flag set.
//  FAIL: page_fail_hold_l=0 and pf_hold_code_h stable until pf_ack_h=1. The following clock is
//   IDLE, with the error flag and code cleared and retry reset.
//  pf_ack_h outside FAIL is ignored. A new request arriving in the same clock as the FAIL exit is
//   not taken; it is sampled in IDLE on the next clock.
//  pgrf_cyc_a_h=1 in REQ, WAIT, WR, T12 and CHK.
//  Latency, IDLE refill to first PT write, with ack in REQ and data valid 1 clock later: 3 clocks.
// TESTING
//  1 Reset mid-WAIT (crobar_l low for 1 clock) -> next clock IDLE, mem_rd_req_h=0, all strobes inactive.
//  2 Refill, ack at +1, data valid at +3, then ok in CHK -> dir_wr low exactly 1 clk, t12 low
//    exactly 1 clk the cycle after, back to IDLE, error flag never set.
//  3 Data valid with mem_par_err_h=1 -> FAIL, code 5'o02, error_h=1/error_l=0; hold until
//    pf_ack_h, then IDLE with code 0.
//  4 No data for TMO_CYC=64 clocks -> FAIL code 5'o03 on clock 64 of WAIT; data valid on that
//    same clock -> WR instead.
//  5 MAX_RETRY=2, PAG keeps returning refill -> exactly 2 WR/T12 pairs, then FAIL code 5'o05.
//  6 Fail and refill asserted together in IDLE -> FAIL code 5'o01, no mem_rd_req_h;
//    ebox_cyc_a_h=0 -> PAG inputs ignored.

Source files
------------

// File: rtl/csh_pgrf_seq.sv
// Page-refill sequencer: on a PT miss, fetch the page-map word, write PT/PT-dir, retry the lookup.
// All outputs are registered from the next-state so they line up with the state they describe.
module csh_pgrf_seq #(
    parameter int unsigned TMO_CYC   = 64,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic       clk,
    input  logic       crobar_l,
    input  logic       ebox_cyc_a_h,
    input  logic       pag_page_refill_l,
    input  logic       pag_page_fail_l,
    input  logic       pag_page_ok_l,
    output logic       mem_rd_req_h,
    input  logic       mem_rd_ack_h,
    input  logic       mem_data_vld_h,
    input  logic       mem_par_err_h,
    input  logic       pf_ack_h,
    output logic       pgrf_cyc_a_h,
    output logic       page_refill_t12_l,
    output logic       mbox_pt_dir_wr_l,
    output logic       page_refill_error_h,
    output logic       page_refill_error_l,
    output logic       page_fail_hold_l,
    output logic [4:0] pf_hold_code_h
);

    localparam logic [7:0] TmoLast  = 8'(TMO_CYC - 1);
    localparam logic [2:0] MaxRetry = 3'(MAX_RETRY);

    typedef enum logic [2:0] {StIdle, StReq, StWait, StWr, StT12, StChk, StFail} state_e;

    state_e     state_q, state_d;
    logic [7:0] tmo_q, tmo_d;
    logic [2:0] retry_q, retry_d;
    logic [4:0] code_q, code_d;
    logic       err_q, err_d;
    logic       req_q, cyc_q, wr_l_q, t12_l_q, hold_l_q, err_l_q;

    logic pag_fail, pag_refill, pag_ok;

    // PAG results only mean anything while the EBox has a paged reference in flight.
    assign pag_fail   = ebox_cyc_a_h & ~pag_page_fail_l;
    assign pag_refill = ebox_cyc_a_h & ~pag_page_refill_l;
    assign pag_ok     = ebox_cyc_a_h & ~pag_page_ok_l;

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        retry_d = retry_q;
        code_d  = code_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (pag_fail) begin
                    state_d = StFail;
                    code_d  = 5'o01;
                end else if (pag_refill) begin
                    state_d = StReq;
                    retry_d = 3'd1;
                end
            end
            StReq: begin
                if (mem_rd_ack_h) begin
                    tmo_d   = '0;
                    state_d = mem_data_vld_h ? StWr : StWait;
                end
            end
            StWait: begin
                // Returned data beats a coincident timeout.
                if (mem_data_vld_h) begin
                    if (mem_par_err_h) begin
                        state_d = StFail;
                        code_d  = 5'o02;
                        err_d   = 1'b1;
                    end else begin
                        state_d = StWr;
                    end
                end else if (tmo_q == TmoLast) begin
                    state_d = StFail;
                    code_d  = 5'o03;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            StWr:  state_d = StT12;
            StT12: state_d = StChk;
            StChk: begin
                if (pag_fail) begin
                    state_d = StFail;
                    code_d  = 5'o04;
                end else if (pag_refill) begin
                    if (retry_q < MaxRetry) begin
                        retry_d = retry_q + 3'd1;
                        state_d = StReq;
                    end else begin
                        state_d = StFail;
                        code_d  = 5'o05;
                        err_d   = 1'b1;
                    end
                end else if (pag_ok) begin
                    state_d = StIdle;
                    retry_d = '0;
                end
            end
            StFail: begin
                if (pf_ack_h) begin
                    state_d = StIdle;
                    code_d  = '0;
                    err_d   = 1'b0;
                    retry_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge crobar_l) begin
        if (!crobar_l) begin
            state_q  <= StIdle;
            tmo_q    <= '0;
            retry_q  <= '0;
            code_q   <= '0;
            err_q    <= 1'b0;
            err_l_q  <= 1'b1;
            req_q    <= 1'b0;
            cyc_q    <= 1'b0;
            wr_l_q   <= 1'b1;
            t12_l_q  <= 1'b1;
            hold_l_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            tmo_q    <= tmo_d;
            retry_q  <= retry_d;
            code_q   <= code_d;
            err_q    <= err_d;
            err_l_q  <= ~err_d;
            req_q    <= (state_d == StReq);
            cyc_q    <= (state_d == StReq) || (state_d == StWait) || (state_d == StWr) ||
                        (state_d == StT12) || (state_d == StChk);
            wr_l_q   <= (state_d != StWr);
            t12_l_q  <= (state_d != StT12);
            hold_l_q <= (state_d != StFail);
        end
    end

    assign mem_rd_req_h        = req_q;
    assign pgrf_cyc_a_h        = cyc_q;
    assign mbox_pt_dir_wr_l    = wr_l_q;
    assign page_refill_t12_l   = t12_l_q;
    assign page_fail_hold_l    = hold_l_q;
    assign pf_hold_code_h      = code_q;
    assign page_refill_error_h = err_q;
    assign page_refill_error_l = err_l_q;

endmodule
